// File: rtl/moving_sum_inverse.sv
// Inverse of a TAPS-long moving-window sum: recovers x[n] = y[n] - y[n-1] + x[n-TAPS].
// All arithmetic wraps modulo 2^DATA_W; output is registered (one cycle latency).
module moving_sum_inverse #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 4
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [TAPS-1:0][DATA_W-1:0] xhist_q, xhist_d;
  logic [DATA_W-1:0]           yprev_q, yprev_d;
  logic [DATA_W-1:0]           out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic [DATA_W-1:0]           dec_d;

  // xhist_q[TAPS-1] holds x[n-TAPS], the sample leaving the encoder window.
  always_comb begin
    dec_d       = in_data - yprev_q + xhist_q[TAPS-1];
    xhist_d     = xhist_q;
    yprev_d     = yprev_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (clear) begin
      xhist_d    = '0;
      yprev_d    = '0;
      out_data_d = '0;
    end else if (in_valid) begin
      xhist_d     = {xhist_q[TAPS-2:0], dec_d};
      yprev_d     = in_data;
      out_valid_d = 1'b1;
      out_data_d  = dec_d;
    end
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      xhist_q     <= '0;
      yprev_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      xhist_q     <= xhist_d;
      yprev_q     <= yprev_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_moving_sum_inverse.sv
// Directed and randomized checks for moving_sum_inverse (DATA_W=8, TAPS=4).
module tb_moving_sum_inverse;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;

  int checks   = 0;
  int failures = 0;

  moving_sum_inverse #(.DATA_W(8), .TAPS(4)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_data       (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic step(input logic v, input byte d, input logic clr);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clear    = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic feed(input string tag, input byte y, input byte x_exp);
    step(1'b1, y, 1'b0);
    check_eq({tag, "_valid"}, int'(out_valid), 1);
    check_eq({tag, "_data"}, int'($signed(out_data)), int'(x_exp));
  endtask

  task automatic idle_check(input string tag, input byte hold);
    step(1'b0, 8'sd0, 1'b0);
    check_eq({tag, "_valid"}, int'(out_valid), 0);
    check_eq({tag, "_hold"}, int'($signed(out_data)), int'(hold));
  endtask

  byte y1[5] = '{8'sd10, 8'sd30, 8'sd60, 8'sd100, -8'sd116};
  byte x1[5] = '{8'sd10, 8'sd20, 8'sd30, 8'sd40, 8'sd50};

  initial begin
    byte win[4];
    byte xr, yr;
    logic v;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_data", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic stream
    for (int i = 0; i < 5; i++) feed("basic", y1[i], x1[i]);
    idle_check("basic_after", 8'sd50);

    // Same stream with a 3-cycle gap after the 2nd input
    step(1'b0, 8'sd0, 1'b1);
    check_eq("clr_valid", int'(out_valid), 0);
    check_eq("clr_data", int'(out_data), 0);
    for (int i = 0; i < 5; i++) begin
      feed("gap", y1[i], x1[i]);
      if (i == 1) for (int g = 0; g < 3; g++) idle_check("gap_idle", 8'sd20);
    end

    // Constant -128 input: period-4 impulse train, no overflow artefacts
    step(1'b0, 8'sd0, 1'b1);
    for (int i = 0; i < 12; i++)
      feed("const", -8'sd128, (i % 4 == 0) ? -8'sd128 : 8'sd0);

    // clear together with in_valid discards the sample and zeroes history
    step(1'b0, 8'sd0, 1'b1);
    feed("cv_a", 8'sd10, 8'sd10);
    feed("cv_b", 8'sd30, 8'sd20);
    feed("cv_c", 8'sd60, 8'sd30);
    step(1'b1, 8'sd100, 1'b1);
    check_eq("cv_clr_valid", int'(out_valid), 0);
    check_eq("cv_clr_data", int'(out_data), 0);
    feed("cv_after", 8'sd7, 8'sd7);

    // Asynchronous reset mid-stream
    step(1'b0, 8'sd0, 1'b1);
    feed("ar_a", 8'sd10, 8'sd10);
    feed("ar_b", 8'sd30, 8'sd20);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", int'(out_valid), 0);
    check_eq("ar_data", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) feed("ar_post", byte'(i), 8'sd1);

    // Randomized: reference moving sum with random gaps
    step(1'b0, 8'sd0, 1'b1);
    for (int k = 0; k < 4; k++) win[k] = 8'sd0;
    for (int n = 0; n < 1000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        xr = byte'($urandom_range(0, 255));
        win[3] = win[2]; win[2] = win[1]; win[1] = win[0]; win[0] = xr;
        yr = byte'(win[0] + win[1] + win[2] + win[3]);
        feed("rand", yr, xr);
      end else begin
        step(1'b0, byte'($urandom_range(0, 255)), 1'b0);
        check_eq("rand_idle_valid", int'(out_valid), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/moving_sum_inverse.md
Name: moving_sum_inverse

Overview:
- Decoder for the moving-window sum stream: recovers the original signed samples x[n] from y[n] = x[n]+x[n-1]+...+x[n-TAPS+1].
- Uses the recursion x[n] = y[n] - y[n-1] + x[n-TAPS], all arithmetic modulo 2^DATA_W.
- Sits downstream of the moving-average datapath; used in loopback checking and in reconstruction paths.
- Output is exact when both blocks start from reset with zeroed history.

Parameters:
- DATA_W, 8, sample width in bits, two's-complement signed, both input and output.
- TAPS, 4, window length of the encoding sum; legal range 2..16.

Ports:
- system1000  in  1  clock, rising edge.
- system1000_rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous history flush; same effect as reset, but applied at the clock edge.
- in_valid  in  1  in_data carries a sample this cycle.
- in_data  in  DATA_W  signed encoded sample y[n].
- out_valid  out  1  out_data carries a decoded sample.
- out_data  out  DATA_W  signed decoded sample x[n].

Behaviour:
- Reset (asynchronous, system1000_rst=1):
  - y_prev = 0; x history (TAPS entries) = 0.
  - out_valid = 0, out_data = 0.
- No backpressure: every accepted sample produces exactly one output.
- Latency is 1 cycle: the sample accepted at edge k (in_valid=1) gives out_valid=1 and out_data=x[n] after edge k.
- Edge with in_valid=0 and clear=0:
  - out_valid goes to 0.
  - out_data holds its last value.
  - History is unchanged. Gaps of any length are transparent.
- Edge with in_valid=1 and clear=0:
  - d = in_data - y_prev + xhist[TAPS-1], computed in DATA_W bits with wrap-around; no saturation; overflow discarded.
  - out_data <= d; out_valid <= 1; y_prev <= in_data.
  - xhist shifts: xhist[0] <= d, xhist[i] <= xhist[i-1].
- xhist[TAPS-1] is x[n-TAPS], the oldest sample.
- clear=1 at an edge:
  - Same state as reset: history 0, out_valid 0, out_data 0.
  - Takes priority over in_valid; a sample presented in that cycle is discarded, with no output.
- Reset asserted mid-stream: outputs go to 0 immediately, without waiting for a clock edge. The first valid sample after release decodes as if it were stream index 0.
- Implementation: a shift register of TAPS words plus one y_prev word. No combinational path from in_data to out_data.

Test Plan:
- Reset then 5 valid inputs 10,30,60,100,-116 (encoding of 10,20,30,40,50 with 8-bit wrap) -> out_valid pulses one cycle after each input; out_data 10,20,30,40,50.
- Same stream with 3 idle cycles between the 2nd and 3rd inputs -> identical out_data sequence; out_valid=0 and out_data held at 20 during the gap.
- Constant input y=-128 for 12 cycles (x stream -128,0,0,0,-128,0,...) -> out_data -128,0,0,0,-128,0,0,0,-128,... with no overflow artefacts.
- clear=1 together with in_valid=1 after input 60 -> no output that cycle; the next input 7 decodes to 7 (history zeroed).
- Assert system1000_rst asynchronously between edges mid-stream -> out_valid and out_data are 0 before the next edge. After release, stream 1,2,3,4 decodes to 1,1,1,1.
- Randomised: 1000 random signed x through a TAPS=4 reference sum, with random in_valid gaps -> decoder output equals x exactly, in order.
